// File: rtl/pcap_dma_packer.sv
// Packs the pcap_core capture word stream into fixed-length DMA bursts.
// Define PCAP_DMA_TIMEOUT_EN to flush partial bursts after an idle timeout.
module pcap_dma_packer #(
  parameter int AW             = 10,
  parameter int BURST_LEN      = 256,
  parameter int FULL_MARGIN    = 16,
  parameter int TIMEOUT_CYCLES = 1250000
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [31:0]   pcap_dat_i,
  input  logic          pcap_dat_valid_i,
  input  logic          pcap_done_i,
  input  logic          pcap_actv_i,
  output logic          dma_full_o,
  output logic          dma_req_o,
  output logic [AW:0]   dma_len_o,
  input  logic          dma_ack_i,
  input  logic          dma_rd_i,
  output logic [31:0]   dma_dat_o,
  output logic          dma_last_o,
  output logic          dma_done_o,
  output logic          overflow_o,
  output logic [AW:0]   fill_level_o
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_L = (AW+1)'(BURST_LEN);
  localparam logic [AW:0] THRESH  = (AW+1)'(DEPTH - FULL_MARGIN);

  if (BURST_LEN > DEPTH || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
  end

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   rem_q, rem_d;
  logic          actv_q, actv_rise;
  logic          flush_q, ovf_q, full_q;
  logic          wr_en, pop, discard, clr_flush;
  logic          tmo_hit;

  assign actv_rise = pcap_actv_i & ~actv_q;
  assign discard   = actv_rise && (state_q == IDLE);
  assign wr_en     = pcap_dat_valid_i && (level_q != DEPTH_L) && !discard;
  assign pop       = dma_rd_i && (state_q == XFER);
  assign clr_flush = discard || (state_q == DONE);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= pcap_dat_i;
  end

  // A new capture throws away whatever the previous one left behind
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (discard) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      actv_q  <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      actv_q <= pcap_actv_i;
      full_q <= (level_q >= THRESH);
      if (actv_rise) ovf_q <= 1'b0;
      if (pcap_dat_valid_i && level_q == DEPTH_L && !discard)
        ovf_q <= 1'b1;
      if (pcap_done_i)    flush_q <= 1'b1;
      else if (clr_flush) flush_q <= 1'b0;
    end
  end

`ifdef PCAP_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_L = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q;
  logic          tmo_arm;

  assign tmo_arm = (state_q == IDLE) && (level_q != '0) &&
                   (level_q < BURST_L) && !wr_en;
  assign tmo_hit = tmo_arm && (tmo_q == TMO_L);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       tmo_q <= '0;
    else if (!tmo_arm) tmo_q <= '0;
    else if (!tmo_hit) tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        // Full bursts win over a pending flush
        if (!discard) begin
          if (level_q >= BURST_L) begin
            len_d   = BURST_L;
            state_d = REQ;
          end else if ((flush_q || tmo_hit) && level_q != '0) begin
            len_d   = level_q;
            state_d = REQ;
          end else if (flush_q) begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (dma_ack_i) begin
          rem_d   = len_q;
          state_d = XFER;
        end
      end
      XFER: begin
        if (pop) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == (AW+1)'(1)) state_d = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dma_req_o    = (state_q == REQ);
  assign dma_len_o    = len_q;
  assign dma_last_o   = (state_q == XFER) && (rem_q == (AW+1)'(1));
  assign dma_done_o   = (state_q == DONE);
  assign dma_full_o   = full_q;
  assign overflow_o   = ovf_q;
  assign fill_level_o = level_q;
  assign dma_dat_o    = (level_q != '0) ? mem[rd_ptr_q] : '0;

endmodule

// File: doc/pcap_dma_packer.md
Name: pcap_dma_packer

Overview:
- Sits directly downstream of pcap_core. Consumes its 32-bit capture word stream (pcap_dat/pcap_dat_valid) and its end-of-capture indication.
- Buffers words in an internal FIFO and packs them into fixed-length DMA bursts for the host DMA engine.
- Drives the dma_full back-pressure flag into pcap_core.
- On end of capture, flushes any partial burst, then signals completion.

Parameters:
- AW, 10, FIFO address width; depth DEPTH = 2**AW words.
- BURST_LEN, 256, words per full DMA burst; must be ≤ DEPTH.
- FULL_MARGIN, 16, free words remaining at which dma_full_o asserts.
- TIMEOUT_CYCLES, 1250000, idle cycles before a partial flush (optional feature only).

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- pcap_dat_i  in  32  capture data word from pcap_core
- pcap_dat_valid_i  in  1  word strobe; one word per high cycle
- pcap_done_i  in  1  single-cycle end-of-capture pulse
- pcap_actv_i  in  1  capture active; rising edge starts a new capture
- dma_full_o  out  1  back-pressure to pcap_core dma_full_i
- dma_req_o  out  1  burst request
- dma_len_o  out  AW+1  burst length in words, valid while dma_req_o is high
- dma_ack_i  in  1  burst accepted, single cycle
- dma_rd_i  in  1  pop strobe during a burst
- dma_dat_o  out  32  head-of-FIFO word (show-ahead)
- dma_last_o  out  1  current dma_dat_o is the last word of the burst
- dma_done_o  out  1  single-cycle pulse after the final flush completes
- overflow_o  out  1  sticky: a word was dropped
- fill_level_o  out  AW+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0; FIFO empty; state IDLE; flush_pending 0.
  - Reset asserted mid-burst aborts the burst; no done pulse is issued.
- FIFO write:
  - Occurs when pcap_dat_valid_i=1 and level<DEPTH.
  - If the FIFO is full, the word is dropped and overflow_o is set.
  - overflow_o clears only on reset or a pcap_actv_i rising edge.
- Simultaneous write and pop leave the level unchanged. fill_level_o is registered and updates the cycle after the event.
- dma_full_o = registered (level ≥ DEPTH-FULL_MARGIN); one cycle latency.
- dma_dat_o is the show-ahead head word. It updates the cycle after a pop.
- flush_pending:
  - Set by pcap_done_i.
  - A pcap_actv_i rising edge clears it and discards FIFO contents, but only in IDLE.
- State machine IDLE → REQ → XFER → IDLE, plus DONE:
  - IDLE, level ≥ BURST_LEN: latch len=BURST_LEN, go to REQ. This rule takes priority over a flush.
  - IDLE, flush_pending and 0<level<BURST_LEN: latch len=level, go to REQ.
  - IDLE, flush_pending and level=0: go to DONE.
  - REQ: hold dma_req_o=1 and dma_len_o stable until dma_ack_i, then go to XFER with remaining=len. dma_req_o drops in the cycle after the ack.
  - XFER: each dma_rd_i pops one word and decrements remaining.
    - dma_last_o = (remaining==1).
    - The pop at remaining==1 returns to IDLE.
    - dma_rd_i outside XFER is ignored.
    - Because len ≤ level at request time, an underflow cannot occur.
  - DONE: dma_done_o=1 for one cycle, clear flush_pending, return to IDLE.
- pcap_done_i arriving during REQ or XFER is latched. The flush is evaluated on the return to IDLE.
- Words written during a burst accumulate for later bursts.
- Level counter is AW+1 bits; no wrap at DEPTH. Pointers are AW bits and wrap naturally.

Optional Feature:
- Macro: PCAP_DMA_TIMEOUT_EN.
- Defined:
  - A counter runs in IDLE while 0<level<BURST_LEN and no write occurs. Any write or state change resets it.
  - At TIMEOUT_CYCLES, request len=level, as for a flush. flush_pending is unchanged.
- Undefined: partial bursts are issued only after pcap_done_i; no counter logic is built.

Test Plan:
- Write 256 words (value = index), ack, pop 256 → one request with dma_len_o=256; dma_dat_o 0..255 in order; dma_last_o only on 255; dma_done_o stays 0.
- Write 300 words then pulse pcap_done_i → bursts of len 256 then 44, followed by a dma_done_o pulse; level ends at 0.
- AW=4, FULL_MARGIN=2, no reads, write 20 words:
  - dma_full_o rises one cycle after the level reaches 14.
  - Level stops at 16; overflow_o=1.
  - A pcap_actv_i rising edge clears overflow_o.
- Write and pop in the same cycle during XFER → fill_level_o unchanged; data order preserved.
- Pulse pcap_done_i with the FIFO empty → dma_done_o pulses 2 cycles later with no request.
- Assert reset_i mid-XFER → dma_req_o, dma_last_o and fill_level_o read 0 immediately, with no clock edge needed.
- With PCAP_DMA_TIMEOUT_EN, TIMEOUT_CYCLES=100, write 10 words then idle → request len=10 after 100 cycles.
